charbuf_writer: RTL and testbench



---
 rtl/charbuf_pkg.sv | 26 ++
 rtl/charbuf_cursor.sv | 88 ++++++++
 rtl/charbuf_writer.sv | 185 ++++++++++++++++++
 tb/tb_charbuf_writer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charbuf_pkg.sv
// Shared states, control codes and address width for the character-buffer writer.
package charbuf_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    WRITE    = 2'd2,
    CLR_LINE = 2'd3
  } state_t;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_TAB = 8'h09;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/charbuf_cursor.sv
// Cursor, scroll origin and incrementally maintained physical line base for the
// circular row ring; flags when a newline has to scroll the screen.
module charbuf_cursor
  import charbuf_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_i,
  input  logic              nl_i,
  input  logic              cr_i,
  input  logic              bs_i,
  input  logic              tab_i,
  input  logic              home_i,
  output logic [6:0]        col_o,
  output logic [5:0]        row_o,
  output logic [5:0]        top_o,
  output logic [ADDR_W-1:0] base_o,
  output logic              scroll_o
);

  localparam logic [6:0]        COL_MAX   = 7'(COLS - 1);
  localparam logic [5:0]        ROW_MAX   = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(COLS * (ROWS - 1));

  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [5:0]        top_q, top_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wrap, do_nl;

  function automatic logic [6:0] tab_stop(input logic [6:0] c);
    logic [7:0] t;
    t = {1'b0, c | 7'd7} + 8'd1;
    return (t > {1'b0, COL_MAX}) ? COL_MAX : t[6:0];
  endfunction

  assign wrap     = adv_i && (col_q == COL_MAX);
  assign do_nl    = nl_i || wrap;
  assign scroll_o = do_nl && (row_q == ROW_MAX);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    top_d  = top_q;
    base_d = base_q;
    if (home_i) begin
      col_d  = '0;
      row_d  = '0;
      top_d  = '0;
      base_d = '0;
    end else begin
      if (adv_i)                     col_d = wrap ? 7'd0 : col_q + 7'd1;
      else if (cr_i)                 col_d = '0;
      else if (bs_i && col_q != '0)  col_d = col_q - 7'd1;
      else if (tab_i)                col_d = tab_stop(col_q);
      // The physical row advances by one on every newline, scroll or not.
      if (do_nl) begin
        base_d = (base_q == LAST_BASE) ? '0 : base_q + COLS_A;
        if (row_q == ROW_MAX) top_d = (top_q == ROW_MAX) ? 6'd0 : top_q + 6'd1;
        else                  row_d = row_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      top_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      top_q  <= top_d;
      base_q <= base_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign top_o  = top_q;
  assign base_o = base_q;

endmodule

// File: rtl/charbuf_writer.sv
// UART-byte to character-buffer writer with cursor tracking and ring scrolling.
// Define CHARBUF_WRITER_TAB_EN to make 0x09 advance to the next 8-column stop.
module charbuf_writer
  import charbuf_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 48,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_ce,
  output logic        mem_wre,
  output logic [11:0] mem_ad,
  output logic [7:0]  mem_din,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic [5:0]  top_row,
  output logic        busy
);

`ifdef CHARBUF_WRITER_TAB_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [7:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [7:0]        din_q, din_d;
  logic              busy_q, busy_d;

  logic              adv_s, nl_s, cr_s, bs_s, tab_s, home_s, scroll_s;
  logic [ADDR_W-1:0] line_base;
  logic              accept;

  charbuf_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .adv_i    (adv_s),
    .nl_i     (nl_s),
    .cr_i     (cr_s),
    .bs_i     (bs_s),
    .tab_i    (tab_s),
    .home_i   (home_s),
    .col_o    (cursor_col),
    .row_o    (cursor_row),
    .top_o    (top_row),
    .base_o   (line_base),
    .scroll_o (scroll_s)
  );

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    byte_d     = byte_q;
    clr_cnt_d  = clr_cnt_q;
    rx_ready_d = 1'b0;
    we_d       = 1'b0;
    ad_d       = ad_q;
    din_d      = din_q;
    busy_d     = 1'b0;
    adv_s      = 1'b0;
    nl_s       = 1'b0;
    cr_s       = 1'b0;
    bs_s       = 1'b0;
    tab_s      = 1'b0;
    home_s     = 1'b0;
    case (state_q)
      CLR_ALL: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        ad_d   = clr_cnt_q;
        din_d  = FILL_CHAR;
        if (clr_cnt_q == LAST_ALL) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end
      CLR_LINE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        ad_d   = line_base + clr_cnt_q;
        din_d  = FILL_CHAR;
        if (clr_cnt_q == LAST_COL) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end
      WRITE: begin
        we_d  = 1'b1;
        ad_d  = line_base + {5'b0, cursor_col};
        din_d = byte_q;
        adv_s = 1'b1;
        if (scroll_s) begin
          state_d = CLR_LINE;
        end else begin
          state_d    = IDLE;
          rx_ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (pend_q) begin
          // Control byte latched last cycle: apply it now.
          pend_d     = 1'b0;
          rx_ready_d = 1'b1;
          case (byte_q)
            CH_CR:  cr_s  = 1'b1;
            CH_LF:  nl_s  = 1'b1;
            CH_BS:  bs_s  = 1'b1;
            CH_TAB: tab_s = TAB_EN;
            CH_FF: begin
              home_s     = 1'b1;
              rx_ready_d = 1'b0;
              state_d    = CLR_ALL;
            end
            default: ;
          endcase
          if (scroll_s) begin
            state_d    = CLR_LINE;
            rx_ready_d = 1'b0;
          end
        end else if (accept) begin
          byte_d = rx_data;
          if (is_print(rx_data)) state_d = WRITE;
          else                   pend_d  = 1'b1;
        end else begin
          rx_ready_d = 1'b1;
        end
      end
      default: state_d = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_ALL;
      pend_q     <= 1'b0;
      clr_cnt_q  <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      ad_q       <= '0;
      din_q      <= FILL_CHAR;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      clr_cnt_q  <= clr_cnt_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      ad_q       <= ad_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  assign rx_ready = rx_ready_q;
  assign mem_ce   = we_q;
  assign mem_wre  = we_q;
  assign mem_ad   = ad_q;
  assign mem_din  = din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_charbuf_writer.sv
// Directed bench for charbuf_writer: a screen-level model predicts every buffer
// write and the cursor; a per-cycle compare process checks the write stream.
module tb_charbuf_writer;

  localparam int         COLS = 80;
  localparam int         ROWS = 48;
  localparam logic [7:0] FILL = 8'h20;
  localparam int         LIM  = 20000;

`ifdef CHARBUF_WRITER_TAB_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_ce;
  logic        mem_wre;
  logic [11:0] mem_ad;
  logic [7:0]  mem_din;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [5:0]  top_row;
  logic        busy;

  always #5 clk = ~clk;

  charbuf_writer #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(FILL)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_ce     (mem_ce),
    .mem_wre    (mem_wre),
    .mem_ad     (mem_ad),
    .mem_din    (mem_din),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .top_row    (top_row),
    .busy       (busy)
  );

  typedef struct {
    int ad;
    int d;
    bit clr;
  } wr_t;

  wr_t exp_q[$];
  int  m_col, m_row, m_top;
  int  n_chk = 0;
  int  n_pass = 0;
  int  last_ad = -1;
  int  last_din = -1;
  int  busy_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Screen model: physical address derived directly from ring position.
  function automatic int phys(input int col, input int row);
    return ((m_top + row) % ROWS) * COLS + col;
  endfunction

  function automatic void m_push(input int ad, input int d, input bit clr);
    wr_t e;
    e.ad = ad; e.d = d; e.clr = clr;
    exp_q.push_back(e);
  endfunction

  function automatic void m_full_clear();
    for (int a = 0; a < COLS * ROWS; a++) m_push(a, FILL, 1'b1);
  endfunction

  function automatic void m_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < COLS; c++) m_push(phys(c, m_row), FILL, 1'b1);
    end
  endfunction

  function automatic void m_apply(input int b);
    if (b >= 32 && b <= 126) begin
      m_push(phys(m_col, m_row), b, 1'b0);
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_newline();
      end else m_col++;
    end else begin
      case (b)
        13: m_col = 0;
        10: m_newline();
        8:  if (m_col > 0) m_col--;
        12: begin m_top = 0; m_row = 0; m_col = 0; m_full_clear(); end
        9:  if (TAB_EN) m_col = (((m_col | 7) + 1) > COLS - 1) ? COLS - 1 : (m_col | 7) + 1;
        default: ;
      endcase
    end
  endfunction

  function automatic void m_reset();
    m_col = 0; m_row = 0; m_top = 0;
    exp_q.delete();
    m_full_clear();
  endfunction

  task automatic cycle_compare();
    wr_t e;
    if (reset) return;
    if (busy) busy_cyc++;
    if (mem_ce) begin
      if (exp_q.size() == 0) chk("spurious_write", int'(mem_ce), 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_ad", int'(mem_ad), e.ad);
        chk("wr_din", int'(mem_din), e.d);
        chk("wr_wre", int'(mem_wre), 1);
        chk("wr_busy", int'(busy), int'(e.clr));
        last_ad  = int'(mem_ad);
        last_din = int'(mem_din);
      end
    end else chk("busy_without_write", int'(busy), 0);
    if (busy) chk("ready_while_busy", int'(rx_ready), 0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("send_timeout", int'(rx_ready), 1);
    m_apply(int'(b));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #1;
    while (!(rx_ready && !busy) && n < LIM) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_reached", int'(rx_ready && !busy), 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("cursor_col", int'(cursor_col), m_col);
    chk("cursor_row", int'(cursor_row), m_row);
    chk("top_row", int'(top_row), m_top);
  endtask

  task automatic check_reset_values();
    chk("rst_ce", int'(mem_ce), 0);
    chk("rst_wre", int'(mem_wre), 0);
    chk("rst_ad", int'(mem_ad), 0);
    chk("rst_din", int'(mem_din), 32);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_top", int'(top_row), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(rx_ready), 0);
  endtask

  initial begin
    int b0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fork
      forever begin
        @(negedge clk);
        cycle_compare();
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_values();
    m_reset();
    @(negedge clk); #4 reset = 1'b0;
    wait_idle();
    chk("power_up_busy_cycles", busy_cyc, 3840);
    chk("power_up_last_ad", last_ad, 3839);

    send_str("AB");
    wait_idle();
    chk("ab_last_ad", last_ad, 1);
    chk("ab_last_din", last_din, 8'h42);
    chk("ab_col", int'(cursor_col), 2);

    send(8'h0D);
    send_n("x", 80);
    wait_idle();
    chk("row_fill_last_ad", last_ad, 79);
    chk("row_fill_col", int'(cursor_col), 0);
    chk("row_fill_row", int'(cursor_row), 1);
    send("y");
    wait_idle();
    chk("next_row_ad", last_ad, 80);
    chk("next_row_din", last_din, 8'h79);

    send_str("abcd");
    wait_idle();
    chk("col5", int'(cursor_col), 5);
    send(8'h08);
    wait_idle();
    chk("bs_col4", int'(cursor_col), 4);
    send(8'h0D);
    wait_idle();
    chk("cr_col0", int'(cursor_col), 0);
    send(8'h08);
    wait_idle();
    chk("bs_at_col0", int'(cursor_col), 0);

    send_str("abc");
    send(8'h09);
    wait_idle();
    chk("tab_from_3", int'(cursor_col), TAB_EN ? 8 : 3);
    send(8'h0D);
    send_n("z", 78);
    send(8'h09);
    wait_idle();
    chk("tab_from_78", int'(cursor_col), TAB_EN ? 79 : 78);

    send(8'h0D);
    send(8'h01);
    send(8'h7F);
    send(8'hFF);
    wait_idle();
    chk("ignored_col", int'(cursor_col), 0);

    send_n(8'h0A, 46);
    wait_idle();
    chk("bottom_row", int'(cursor_row), 47);
    chk("bottom_top", int'(top_row), 0);
    b0 = busy_cyc;
    send(8'h0A);
    wait_idle();
    chk("scroll_top", int'(top_row), 1);
    chk("scroll_row", int'(cursor_row), 47);
    chk("scroll_last_ad", last_ad, 79);
    chk("scroll_last_din", last_din, 32);
    chk("scroll_busy_cycles", busy_cyc - b0, 80);

    send(8'h0D);
    send_n("w", 80);
    wait_idle();
    chk("wrap_top", int'(top_row), 2);
    chk("wrap_row", int'(cursor_row), 47);
    chk("wrap_last_ad", last_ad, 159);

    b0 = busy_cyc;
    send(8'h0C);
    wait_idle();
    chk("ff_top", int'(top_row), 0);
    chk("ff_col", int'(cursor_col), 0);
    chk("ff_busy_cycles", busy_cyc - b0, 3840);
    chk("ff_last_ad", last_ad, 3839);

    send("Q");
    send(8'h0C);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    check_reset_values();
    m_reset();
    b0 = busy_cyc;
    @(negedge clk); #4 reset = 1'b0;
    wait_idle();
    chk("rerst_busy_cycles", busy_cyc - b0, 3840);
    chk("rerst_last_ad", last_ad, 3839);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
